fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_if.sv | 36 +++
 rtl/fetch.sv | 97 +++++++++
 tb/tb_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared CPU definitions for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_VEC_LO = 3'd0,
    ST_VEC_HI = 3'd1,
    ST_FETCH  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_JAM    = 3'd4
  } fetch_state_t;

  localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;
  localparam logic [7:0]  IR_RESET     = 8'hEA;

endpackage

// File: rtl/fetch_if.sv
// Memory bus and sequencer handshake between the fetch unit and its neighbours.
interface fetch_if;

  // memory side
  logic        i_ready;
  logic [7:0]  i_data;
  logic [15:0] o_addr;
  logic        o_rd;
  logic        o_sync;

  // decoder / sequencer side
  logic [7:0]  o_opcode;
  logic        o_opcode_valid;
  logic [15:0] o_pc;
  logic [7:0]  o_operand;
  logic        i_pc_inc;
  logic        i_pc_load;
  logic [15:0] i_pc_new;
  logic        i_ex_bus;
  logic [15:0] i_ex_addr;
  logic        i_done;
  logic        i_jam;

  modport master (
    input  i_ready, i_data, i_pc_inc, i_pc_load, i_pc_new,
           i_ex_bus, i_ex_addr, i_done, i_jam,
    output o_addr, o_rd, o_sync, o_opcode, o_opcode_valid, o_pc, o_operand
  );

  modport slave (
    output i_ready, i_data, i_pc_inc, i_pc_load, i_pc_new,
           i_ex_bus, i_ex_addr, i_done, i_jam,
    input  o_addr, o_rd, o_sync, o_opcode, o_opcode_valid, o_pc, o_operand
  );

endinterface

// File: rtl/fetch.sv
// Instruction fetch unit: reset-vector load, opcode fetch, PC/operand tracking.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_VEC_LO | reading low byte of reset vector at 0xFFFC
// ST_VEC_HI | reading high byte at 0xFFFD, PC loaded from vector
// ST_FETCH  | opcode fetch at PC (o_sync high)
// ST_EXEC   | sequencer executes; may consume bytes, jump, own bus
// ST_JAM    | halted on illegal opcode until reset
module fetch
  import fetch_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  fetch_if.master  bus
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   vec_lo_q, vec_lo_d;
  logic [7:0]   operand_q, operand_d;
  logic         opv_q, opv_d;

  // All registered state; i_ready low freezes everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_VEC_LO;
      pc_q      <= 16'h0000;
      ir_q      <= IR_RESET;
      vec_lo_q  <= 8'h00;
      operand_q <= 8'h00;
      opv_q     <= 1'b0;
    end else if (bus.i_ready) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      vec_lo_q  <= vec_lo_d;
      operand_q <= operand_d;
      opv_q     <= opv_d;
    end
  end

  // Next-state and datapath updates; sequencer inputs only matter in EXEC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    vec_lo_d  = vec_lo_q;
    operand_d = operand_q;
    opv_d     = 1'b0;
    case (state_q)
      ST_VEC_LO: begin
        vec_lo_d = bus.i_data;
        state_d  = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        pc_d    = {bus.i_data, vec_lo_q};
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = bus.i_data;
        pc_d    = pc_q + 16'd1;
        opv_d   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // operand capture is independent of a same-cycle jump
        if (bus.i_pc_inc) operand_d = bus.i_data;
        if (bus.i_pc_load)     pc_d = bus.i_pc_new;
        else if (bus.i_pc_inc) pc_d = pc_q + 16'd1;
        if (bus.i_jam)       state_d = ST_JAM;
        else if (bus.i_done) state_d = ST_FETCH;
      end
      ST_JAM: state_d = ST_JAM;
      default: state_d = ST_VEC_LO;
    endcase
  end

  // Address mux and status outputs.
  always_comb begin
    case (state_q)
      ST_VEC_LO: bus.o_addr = RESET_VEC_LO;
      ST_VEC_HI: bus.o_addr = RESET_VEC_HI;
      ST_EXEC:   bus.o_addr = bus.i_ex_bus ? bus.i_ex_addr : pc_q;
      default:   bus.o_addr = pc_q;
    endcase
  end

  assign bus.o_rd           = 1'b1;
  assign bus.o_sync         = (state_q == ST_FETCH);
  assign bus.o_opcode       = ir_q;
  assign bus.o_opcode_valid = opv_q;
  assign bus.o_pc           = pc_q;
  assign bus.o_operand      = operand_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch unit against a cycle-level reference model.
module tb_fetch;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fetch_if bus ();

  fetch dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  logic [7:0] mem [65536];
  assign bus.i_data = mem[bus.o_addr];

  // reference model: phase names are the bench's own
  localparam int P_VLO = 0, P_VHI = 1, P_FETCH = 2, P_EXEC = 3, P_JAM = 4;
  int          m_phase;
  logic [15:0] m_pc;
  logic [7:0]  m_ir, m_vlo, m_op;
  logic        m_valid;

  task automatic model_reset();
    m_phase = P_VLO; m_pc = 16'h0000; m_ir = 8'hEA;
    m_vlo = 8'h00; m_op = 8'h00; m_valid = 1'b0;
  endtask

  function automatic logic [15:0] exp_addr();
    case (m_phase)
      P_VLO:   return 16'hFFFC;
      P_VHI:   return 16'hFFFD;
      P_EXEC:  return bus.i_ex_bus ? bus.i_ex_addr : m_pc;
      default: return m_pc;
    endcase
  endfunction

  task automatic model_step(input logic [7:0] d);
    if (!bus.i_ready) return;
    m_valid = 1'b0;
    case (m_phase)
      P_VLO: begin m_vlo = d; m_phase = P_VHI; end
      P_VHI: begin m_pc = {d, m_vlo}; m_phase = P_FETCH; end
      P_FETCH: begin m_ir = d; m_pc = m_pc + 16'd1; m_valid = 1'b1; m_phase = P_EXEC; end
      P_EXEC: begin
        if (bus.i_pc_inc) m_op = d;
        if (bus.i_pc_load) m_pc = bus.i_pc_new;
        else if (bus.i_pc_inc) m_pc = m_pc + 16'd1;
        if (bus.i_jam) m_phase = P_JAM;
        else if (bus.i_done) m_phase = P_FETCH;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("addr", bus.o_addr, exp_addr());
    chk("sync", {15'd0, bus.o_sync}, {15'd0, (m_phase == P_FETCH)});
    chk("rd", {15'd0, bus.o_rd}, 16'd1);
    chk("pc", bus.o_pc, m_pc);
    chk("opcode", {8'd0, bus.o_opcode}, {8'd0, m_ir});
    chk("opcode_valid", {15'd0, bus.o_opcode_valid}, {15'd0, m_valid});
    chk("operand", {8'd0, bus.o_operand}, {8'd0, m_op});
  endtask

  // one clock: drive, check pre-edge address, clock, check everything
  task automatic cycle(input logic rdy, input logic inc, input logic load,
                       input logic [15:0] pnew, input logic exb,
                       input logic [15:0] exa, input logic done, input logic jam);
    logic [7:0] d;
    bus.i_ready = rdy; bus.i_pc_inc = inc; bus.i_pc_load = load;
    bus.i_pc_new = pnew; bus.i_ex_bus = exb; bus.i_ex_addr = exa;
    bus.i_done = done; bus.i_jam = jam;
    #1;
    chk("addr_pre", bus.o_addr, exp_addr());
    d = mem[exp_addr()];
    @(posedge i_clk);
    model_step(d);
    #1;
    chk_all();
  endtask

  task automatic idle(input logic rdy);
    cycle(rdy, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_reset();
    #1;
    chk("rst_addr", bus.o_addr, 16'hFFFC);
    chk_all();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [15:0] a0, a1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h1234] = 8'h5C; mem[16'hFFFF] = 8'h18;
    bus.i_ready = 1'b1; bus.i_pc_inc = 1'b0; bus.i_pc_load = 1'b0;
    bus.i_pc_new = 16'h0; bus.i_ex_bus = 1'b0; bus.i_ex_addr = 16'h0;
    bus.i_done = 1'b0; bus.i_jam = 1'b0;

    model_reset();
    @(posedge i_clk); #1;
    do_reset();

    // vector fetch then first opcode at 0x8000
    idle(1'b1);
    idle(1'b1);
    chk("first_fetch_addr", bus.o_addr, 16'h8000);
    chk("first_fetch_sync", {15'd0, bus.o_sync}, 16'd1);
    idle(1'b1);
    chk("opcode_A9", {8'd0, bus.o_opcode}, 16'h00A9);
    chk("pc_8001", bus.o_pc, 16'h8001);
    // consume operand, stay in EXEC
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("operand_42", {8'd0, bus.o_operand}, 16'h0042);
    chk("pc_8002", bus.o_pc, 16'h8002);
    chk("valid_one_cycle", {15'd0, bus.o_opcode_valid}, 16'd0);

    // jump to 0xFFFF and fetch there: wraps to 0x0000
    cycle(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0123, 1'b1, 1'b0);
    idle(1'b1);
    chk("pc_wrap", bus.o_pc, 16'h0000);

    // load wins over inc, operand still captured, done goes to fetch at target
    cycle(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("load_target", bus.o_addr, 16'h1234);
    chk("operand_on_load", {8'd0, bus.o_operand}, {8'd0, mem[16'h0000]});

    // stall in FETCH for three cycles
    a0 = bus.o_addr;
    repeat (3) idle(1'b0);
    chk("stall_addr", bus.o_addr, a0);
    chk("stall_pc", bus.o_pc, 16'h1234);
    idle(1'b1);
    chk("resume_opcode", {8'd0, bus.o_opcode}, 16'h005C);
    chk("resume_valid", {15'd0, bus.o_opcode_valid}, 16'd1);
    // valid held through a stall
    idle(1'b0);
    chk("valid_hold", {15'd0, bus.o_opcode_valid}, 16'd1);

    // jam beats done
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    a1 = bus.o_pc;
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 16'h4444, 1'b1, 16'h5555, 1'b1, 1'b0);
    chk("jam_sync", {15'd0, bus.o_sync}, 16'd0);
    chk("jam_pc", bus.o_pc, a1);
    do_reset();
    chk("jam_reset_addr", bus.o_addr, 16'hFFFC);

    // randomized run with occasional resets and jams
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 8, 1'($urandom), ($urandom_range(0, 3) == 0),
                 16'($urandom), 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
